rsa_ctrl: RTL and testbench

RSA_CTRL -- requirements
Module: rsa_ctrl

---
 rtl/rsa_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rsa_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_ctrl.sv
// rtl/rsa_ctrl.sv - sequencer that loads N/M/E into an RSA core, starts it and streams the result out
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   clr                   synchronous abort back to IDLE
//   in_valid/in_ready/in_data     operand byte stream (N, then M, then E; LSB first)
//   out_valid/out_ready/out_data  result byte stream (LSB first)
//   core_reg_sel/core_addr/core_wdata/core_we_n/core_oe_n/core_start_n  core register port
//   core_busy, core_rdata core status and registered read data
//   busy, done, err       status: not idle / one-cycle completion pulse / sticky timeout
module rsa_ctrl #(
    parameter int NBYTES  = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] core_reg_sel,
    output logic [4:0] core_addr,
    output logic [7:0] core_wdata,
    output logic       core_we_n,
    output logic       core_oe_n,
    output logic       core_start_n,
    input  logic       core_busy,
    input  logic [7:0] core_rdata,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE, LD_N, LD_M, LD_E, START, WAIT, RD_ISSUE, RD_CAP, RD_OUT, ERR
    } state_t;

    localparam logic [4:0]  LAST      = 5'(NBYTES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        seen_hi_q, seen_hi_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        done_q, done_d;
    logic        load_st;
    logic        wr;

    always_comb begin
        load_st = (state_q == IDLE) || (state_q == LD_N) ||
                  (state_q == LD_M) || (state_q == LD_E);
        // clr suppresses the write of a byte arriving in the same cycle; the
        // reset term keeps the write strobe quiet while reset is held.
        wr = load_st && in_valid && !clr && reset;

        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        seen_hi_d  = seen_hi_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE, LD_N, LD_M, LD_E: begin
                if (wr) begin
                    cnt_d = cnt_q + 5'd1;
                    if (state_q == IDLE) state_d = LD_N;
                    if (cnt_q == LAST) begin
                        cnt_d = 5'd0;
                        case (state_q)
                            IDLE, LD_N: state_d = LD_M;
                            LD_M:       state_d = LD_E;
                            default:    state_d = START;
                        endcase
                    end
                end
            end
            START: begin
                state_d   = WAIT;
                wcnt_d    = 16'd0;
                seen_hi_d = 1'b0;
            end
            WAIT: begin
                seen_hi_d = seen_hi_q | core_busy;
                // A falling busy wins over an expiring timeout in the same cycle.
                if (seen_hi_q && !core_busy) begin
                    state_d = RD_ISSUE;
                end else if (wcnt_q >= WAIT_LAST) begin
                    state_d = ERR;
                end
                if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
            end
            RD_ISSUE: state_d = RD_CAP;
            RD_CAP: begin
                out_data_d = core_rdata;
                state_d    = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = 5'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d   = IDLE;
            cnt_d     = 5'd0;
            wcnt_d    = 16'd0;
            seen_hi_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            wcnt_q     <= 16'd0;
            seen_hi_q  <= 1'b0;
            out_data_q <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            seen_hi_q  <= seen_hi_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    core_reg_sel = wr ? 2'd3 : 2'd0;
            LD_N:    core_reg_sel = 2'd3;
            LD_M:    core_reg_sel = 2'd1;
            LD_E:    core_reg_sel = 2'd2;
            default: core_reg_sel = 2'd0;
        endcase
    end

    assign in_ready     = load_st;
    assign out_valid    = (state_q == RD_OUT);
    assign out_data     = out_data_q;
    assign core_addr    = cnt_q;
    assign core_wdata   = wr ? in_data : 8'd0;
    assign core_we_n    = !wr;
    assign core_oe_n    = !(state_q == RD_ISSUE);
    assign core_start_n = !(state_q == START);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = (state_q == ERR);

endmodule

// File: tb/tb_rsa_ctrl.sv
// tb/tb_rsa_ctrl.sv - randomized self-checking bench for rsa_ctrl with a behavioural core model
module tb_rsa_ctrl;
    localparam int NB = 32;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       core_busy = 1'b0;
    logic [7:0] core_rdata = 8'd0;
    logic       in_ready, out_valid, core_we_n, core_oe_n, core_start_n, busy, done, err;
    logic [7:0] out_data, core_wdata;
    logic [1:0] core_reg_sel;
    logic [4:0] core_addr;

    rsa_ctrl #(.NBYTES(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_reg_sel(core_reg_sel), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_we_n(core_we_n), .core_oe_n(core_oe_n), .core_start_n(core_start_n),
        .core_busy(core_busy), .core_rdata(core_rdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] op [0:3*NB-1];
    logic [7:0] res [0:NB-1];
    int wr_cnt, oe_cnt, start_cnt, excl_err, ord_err, stab_err;
    int blen, bcnt, cyc_n, start_cyc;

    initial begin
        wr_cnt = 0; oe_cnt = 0; start_cnt = 0; excl_err = 0; ord_err = 0;
        stab_err = 0; blen = 0; bcnt = 0; cyc_n = 0; start_cyc = -1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, {in_ready, out_valid, out_data, core_reg_sel, core_addr, core_wdata,
                       core_we_n, core_oe_n, core_start_n, busy, done, err},
                 {1'b1, 1'b0, 8'h00, 2'b00, 5'h00, 8'h00, 3'b111, 3'b000});
    endtask

    always @(posedge clk) cyc_n++;

    // Core model plus strobe monitor, sampled mid-cycle after the driver settles.
    always @(negedge clk) begin
        int exp_sel;
        #2;
        if (reset) begin
            if (int'(!core_we_n) + int'(!core_oe_n) + int'(!core_start_n) > 1) excl_err++;
            if (!core_we_n) begin
                if (wr_cnt >= 3*NB) begin
                    ord_err++;
                end else begin
                    exp_sel = (wr_cnt / NB == 0) ? 3 : (wr_cnt / NB == 1) ? 1 : 2;
                    if (core_reg_sel !== 2'(exp_sel) || core_addr !== 5'(wr_cnt % NB) ||
                        core_wdata !== op[wr_cnt]) ord_err++;
                end
                wr_cnt++;
            end
            if (!core_oe_n) begin
                if (core_reg_sel !== 2'd0 || core_addr !== 5'(oe_cnt % NB)) ord_err++;
                core_rdata = res[core_addr];
                oe_cnt++;
            end
            if (!core_start_n) begin
                start_cnt++;
                start_cyc = cyc_n;
                if (blen > 0) begin
                    core_busy = 1'b1;
                    bcnt = blen;
                end
            end else if (core_busy) begin
                bcnt--;
                if (bcnt == 0) core_busy = 1'b0;
            end
        end
    end

    task automatic randomize_data();
        for (int i = 0; i < 3*NB; i++) op[i] = 8'($urandom);
        for (int i = 0; i < NB; i++) res[i] = 8'($urandom);
    endtask

    // kind: 0 = full operation, 1 = async reset at load byte abort_k, 2 = clr at load byte abort_k
    task automatic run_op(input int bl, input bit stall, input int abort_k, input int kind);
        int k = 0;
        int nout = 0;
        int stall_cnt = 0;
        int oe_snap = 0;
        int err_cyc = -1;
        bit got_done = 1'b0;
        bit last_rdy = 1'b0;
        bit hold_v = 1'b0;
        logic [7:0] hold_d = 8'd0;
        logic [7:0] got [0:NB-1];
        wr_cnt = 0; oe_cnt = 0; start_cnt = 0; stab_err = 0; ord_err = 0;
        blen = bl; start_cyc = -1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (in_valid && last_rdy) k++;
            if (done) got_done = 1'b1;
            if (err && err_cyc < 0) err_cyc = cyc_n;
            if (got_done || err_cyc >= 0) begin
                in_valid = 1'b0;
                out_ready = 1'b0;
                break;
            end
            if (kind != 0 && k == abort_k) begin
                in_valid = 1'b1;
                in_data = op[k];
                if (kind == 1) begin
                    reset = 1'b0;
                    #1 check_reset_outs("reset_async_mid_load");
                    in_valid = 1'b0;
                    repeat (2) @(negedge clk);
                    reset = 1'b1;
                end else begin
                    clr = 1'b1;
                    #3 check_eq("clr_blocks_write", wr_cnt, k);
                    @(negedge clk);
                    clr = 1'b0;
                    in_valid = 1'b0;
                    check_eq("clr_to_idle", {busy, in_ready, core_addr}, {1'b0, 1'b1, 5'd0});
                end
                return;
            end
            if (k < 3*NB) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data = in_valid ? op[k] : 8'($urandom);
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
            end
            last_rdy = in_ready;
            if (hold_v && out_data !== hold_d) stab_err++;
            if (stall && nout == 5 && out_valid && stall_cnt < 10) begin
                if (stall_cnt == 0) oe_snap = oe_cnt;
                out_ready = 1'b0;
                stall_cnt++;
                if (stall_cnt == 10) check_eq("stall_no_oe", oe_cnt, oe_snap);
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
            if (out_valid && out_ready) begin
                if (nout < NB) got[nout] = out_data;
                nout++;
                hold_v = 1'b0;
            end else begin
                hold_v = out_valid;
                hold_d = out_data;
            end
        end
        if (bl > 0) begin
            check_eq("done_seen", got_done, 1);
            check_eq("idle_at_done", busy, 0);
            check_eq("out_count", nout, NB);
            for (int i = 0; i < NB; i++) check_eq($sformatf("out_byte%0d", i), got[i], res[i]);
            check_eq("we_count", wr_cnt, 3*NB);
            check_eq("start_count", start_cnt, 1);
            check_eq("oe_count", oe_cnt, NB);
            check_eq("strobe_order", ord_err, 0);
            check_eq("out_stable", stab_err, 0);
        end else begin
            check_eq("timeout_cycles", err_cyc - start_cyc, TO + 1);
            repeat (5) @(negedge clk);
            check_eq("err_sticky", {err, busy, in_ready, out_valid}, {1'b1, 1'b1, 1'b0, 1'b0});
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            check_eq("clr_after_err", {err, busy}, {1'b0, 1'b0});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outs("reset_vals");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3*NB; i++) op[i] = 8'd0;
        for (int i = 0; i < NB; i++) res[i] = 8'd0;
        op[0] = 8'd7; op[NB] = 8'd3; op[2*NB] = 8'd4; res[0] = 8'd4;
        run_op(20, 1'b1, -1, 0);

        repeat (3) begin
            randomize_data();
            run_op(int'($urandom_range(1, 30)), 1'b0, -1, 0);
        end

        randomize_data();
        run_op(0, 1'b0, -1, 0);

        randomize_data();
        run_op(5, 1'b0, NB + 10, 1);
        randomize_data();
        run_op(5, 1'b0, -1, 0);

        randomize_data();
        run_op(5, 1'b0, 2*NB + 3, 2);
        run_op(7, 1'b0, -1, 0);

        check_eq("strobe_exclusive", excl_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
